// File: rtl/frame_streamer.sv
// rtl/frame_streamer.sv - frame buffer streamed out in raster order, optional zero-pixel flush tail
// Optional feature macro: FRAME_STREAMER_FLUSH_EN (adds FLUSH_PIXELS trailing zero pixels per frame)
module frame_streamer #(
  parameter int PIXEL_WIDTH  = 8,
  parameter int IMAGE_WIDTH  = 8,
  parameter int IMAGE_HEIGHT = 8,
  parameter int FLUSH_PIXELS = 2*IMAGE_WIDTH+2,
  localparam int DEPTH  = IMAGE_WIDTH*IMAGE_HEIGHT,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic [PIXEL_WIDTH-1:0] wr_data,
  input  logic                   start,
  input  logic                   pause,
  output logic [PIXEL_WIDTH-1:0] pixel_out,
  output logic                   valid_out,
  output logic                   sof,
  output logic                   eol,
  output logic                   busy,
  output logic                   done
);

  localparam int COL_W = (IMAGE_WIDTH  < 2) ? 1 : $clog2(IMAGE_WIDTH);
  localparam int FC_W  = (FLUSH_PIXELS < 2) ? 1 : $clog2(FLUSH_PIXELS);

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DONE} state_t;

  state_t                 state_q, state_d;
  logic [ADDR_W-1:0]      idx_q, idx_d;
  logic [COL_W-1:0]       col_q, col_d;
  logic [FC_W-1:0]        flush_cnt_q, flush_cnt_d;
  logic [PIXEL_WIDTH-1:0] pixel_q, pixel_d;
  logic                   valid_q, valid_d;
  logic                   sof_q, sof_d;
  logic                   eol_q, eol_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  // Frame store: plain registers, no reset, read combinationally by the streamer.
  logic [PIXEL_WIDTH-1:0] mem_q [DEPTH];

  logic wr_ok;
  logic last_pix;
  logic last_col;
  logic last_flush;

  // Addresses past the frame are dropped so a stray write cannot alias a valid pixel.
  assign wr_ok      = wr_en && (32'(wr_addr) < DEPTH);
  assign last_pix   = (idx_q == ADDR_W'(DEPTH-1));
  assign last_col   = (col_q == COL_W'(IMAGE_WIDTH-1));
  assign last_flush = (flush_cnt_q == FC_W'(FLUSH_PIXELS-1));

  // Frame store write port; a same-cycle stream read of the address still sees the old pixel.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Next-state and next-output logic; busy/done track the state the outputs were produced in.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    col_d       = col_q;
    flush_cnt_d = flush_cnt_q;
    pixel_d     = pixel_q;
    valid_d     = 1'b0;
    sof_d       = 1'b0;
    eol_d       = 1'b0;
    busy_d      = (state_q == STREAM) || (state_q == FLUSH);
    done_d      = (state_q == DONE);

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = STREAM;
          idx_d       = '0;
          col_d       = '0;
          flush_cnt_d = '0;
        end
      end

      STREAM: begin
        if (!pause) begin
          valid_d = 1'b1;
          pixel_d = mem_q[idx_q];
          sof_d   = (idx_q == '0);
          eol_d   = last_col;
          idx_d   = idx_q + ADDR_W'(1);
          col_d   = last_col ? '0 : col_q + COL_W'(1);
          if (last_pix) begin
            idx_d = '0;
`ifdef FRAME_STREAMER_FLUSH_EN
            flush_cnt_d = '0;
            state_d     = (FLUSH_PIXELS == 0) ? DONE : FLUSH;
`else
            state_d = DONE;
`endif
          end
        end
      end

      FLUSH: begin
        if (!pause) begin
          valid_d     = 1'b1;
          pixel_d     = '0;
          flush_cnt_d = flush_cnt_q + FC_W'(1);
          if (last_flush) begin
            flush_cnt_d = '0;
            state_d     = DONE;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset abandons any frame in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      col_q       <= '0;
      flush_cnt_q <= '0;
      pixel_q     <= '0;
      valid_q     <= 1'b0;
      sof_q       <= 1'b0;
      eol_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      col_q       <= col_d;
      flush_cnt_q <= flush_cnt_d;
      pixel_q     <= pixel_d;
      valid_q     <= valid_d;
      sof_q       <= sof_d;
      eol_q       <= eol_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign pixel_out = pixel_q;
  assign valid_out = valid_q;
  assign sof       = sof_q;
  assign eol       = eol_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
